// File: rtl/axil_bram_pkg.sv
// Shared types and constants for the AXI4-Lite to BRAM bridge.
package axil_bram_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWresp,
        StRead,
        StRwait,
        StRresp
    } state_e;

    localparam logic [1:0] RespOkay = 2'b00;

endpackage

// File: rtl/axil_bram_master_if.sv
// AXI4-Lite slave channels plus the BRAM port driven by the bridge.
interface axil_bram_master_if #(
    parameter int unsigned ADDR_WIDTH = 22,
    parameter int unsigned DATA_WIDTH = 32
);
    // AXI4-Lite
    logic [ADDR_WIDTH-1:0]   s_awaddr;
    logic                    s_awvalid;
    logic                    s_awready;
    logic [DATA_WIDTH-1:0]   s_wdata;
    logic [DATA_WIDTH/8-1:0] s_wstrb;
    logic                    s_wvalid;
    logic                    s_wready;
    logic [1:0]              s_bresp;
    logic                    s_bvalid;
    logic                    s_bready;
    logic [ADDR_WIDTH-1:0]   s_araddr;
    logic                    s_arvalid;
    logic                    s_arready;
    logic [DATA_WIDTH-1:0]   s_rdata;
    logic [1:0]              s_rresp;
    logic                    s_rvalid;
    logic                    s_rready;
    // BRAM
    logic [ADDR_WIDTH-1:0]   bram_addr;
    logic                    bram_en;
    logic [DATA_WIDTH/8-1:0] bram_we;
    logic [DATA_WIDTH-1:0]   bram_wrdata;
    logic [DATA_WIDTH-1:0]   bram_rddata;

    // Bridge side: accepts AXI requests, drives the BRAM.
    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready, bram_rddata,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid,
        output bram_addr, bram_en, bram_we, bram_wrdata
    );

    // Requester side: issues AXI requests, models the BRAM.
    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready, bram_rddata,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid,
        input  bram_addr, bram_en, bram_we, bram_wrdata
    );

endinterface

// File: rtl/axil_bram_master.sv
// AXI4-Lite slave to single-port BRAM bridge, one transaction in flight.
// Write: handshake -> WRITE (BRAM access) -> WRESP (bvalid).
// Read:  handshake -> READ (BRAM access) -> RWAIT (capture) -> RRESP (rvalid).
module axil_bram_master
    import axil_bram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 22,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    axil_bram_master_if.slave bus
);

    localparam int unsigned StrbWidth = DATA_WIDTH / 8;
    // Word alignment: byte-lane bits are always driven as zero.
    localparam logic [ADDR_WIDTH-1:0] AddrMask = ~(ADDR_WIDTH'(3));

    state_e                  state_q;
    logic                    last_was_write_q;
    logic [ADDR_WIDTH-1:0]   bram_addr_q;
    logic                    bram_en_q;
    logic [StrbWidth-1:0]    bram_we_q;
    logic [DATA_WIDTH-1:0]   bram_wrdata_q;
    logic                    bvalid_q;
    logic                    rvalid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic wr_cand;
    logic rd_cand;
    logic grant_wr;
    logic grant_rd;

    // Arbitration in IDLE; on a tie, alternate using the last granted direction.
    always_comb begin
        wr_cand  = bus.s_awvalid && bus.s_wvalid;
        rd_cand  = bus.s_arvalid;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        // Readies are also held low while reset is asserted.
        if (state_q == StIdle && !rst) begin
            if (wr_cand && rd_cand) begin
                grant_wr = !last_was_write_q;
                grant_rd = last_was_write_q;
            end else begin
                grant_wr = wr_cand;
                grant_rd = rd_cand;
            end
        end
    end

    assign bus.s_awready   = grant_wr;
    assign bus.s_wready    = grant_wr;
    assign bus.s_arready   = grant_rd;
    assign bus.s_bresp     = RespOkay;
    assign bus.s_rresp     = RespOkay;
    assign bus.s_bvalid    = bvalid_q;
    assign bus.s_rvalid    = rvalid_q;
    assign bus.s_rdata     = rdata_q;
    assign bus.bram_addr   = bram_addr_q;
    assign bus.bram_en     = bram_en_q;
    assign bus.bram_we     = bram_we_q;
    assign bus.bram_wrdata = bram_wrdata_q;

    // Transaction FSM with registered BRAM and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            last_was_write_q <= 1'b0;
            bram_addr_q      <= '0;
            bram_en_q        <= 1'b0;
            bram_we_q        <= '0;
            bram_wrdata_q    <= '0;
            bvalid_q         <= 1'b0;
            rvalid_q         <= 1'b0;
            rdata_q          <= '0;
        end else begin
            // BRAM strobes are single-cycle pulses.
            bram_en_q <= 1'b0;
            bram_we_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (grant_wr) begin
                        state_q          <= StWrite;
                        last_was_write_q <= 1'b1;
                        bram_en_q        <= 1'b1;
                        bram_we_q        <= bus.s_wstrb;
                        bram_addr_q      <= bus.s_awaddr & AddrMask;
                        bram_wrdata_q    <= bus.s_wdata;
                    end else if (grant_rd) begin
                        state_q          <= StRead;
                        last_was_write_q <= 1'b0;
                        bram_en_q        <= 1'b1;
                        bram_addr_q      <= bus.s_araddr & AddrMask;
                    end
                end
                StWrite: begin
                    state_q  <= StWresp;
                    bvalid_q <= 1'b1;
                end
                StWresp: begin
                    if (bus.s_bready) begin
                        state_q  <= StIdle;
                        bvalid_q <= 1'b0;
                    end
                end
                StRead: begin
                    state_q <= StRwait;
                end
                StRwait: begin
                    state_q  <= StRresp;
                    rdata_q  <= bus.bram_rddata;
                    rvalid_q <= 1'b1;
                end
                StRresp: begin
                    if (bus.s_rready) begin
                        state_q  <= StIdle;
                        rvalid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_bram_master.sv
// Scoreboard bench for axil_bram_master: expected BRAM accesses and B/R
// responses are queued by the stimulus and popped by a negedge monitor.
module tb_axil_bram_master;

    localparam int unsigned AW = 22;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_bram_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

    axil_bram_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    we;
        logic [31:0]   data;
    } bram_op_t;

    bram_op_t    exp_bram[$];
    logic [1:0]  exp_bresp[$];
    logic [31:0] exp_rdata[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // BRAM model: synchronous, read data valid the cycle after a read enable.
    logic [31:0] mem [0:255];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            mem[4]          <= 32'h1234_5678;
            bus.bram_rddata <= 32'h0;
            mem_ready       <= 1'b1;
        end else if (bus.bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.bram_we[b]) mem[bus.bram_addr[9:2]][b*8 +: 8] <= bus.bram_wrdata[b*8 +: 8];
            if (bus.bram_we == 4'h0) bus.bram_rddata <= mem[bus.bram_addr[9:2]];
        end
    end

    // Monitor: every BRAM enable and every B/R handshake pops one expectation.
    bram_op_t op;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.bram_en) begin
                if (exp_bram.size() == 0) fail_now("bram_unexpected");
                else begin
                    op = exp_bram.pop_front();
                    check("bram_addr", 32'(bus.bram_addr), 32'(op.addr));
                    check("bram_we", 32'(bus.bram_we), 32'(op.we));
                    if (op.we != 4'h0) check("bram_wrdata", bus.bram_wrdata, op.data);
                end
            end
            if (bus.s_bvalid && bus.s_bready) begin
                if (exp_bresp.size() == 0) fail_now("b_unexpected");
                else check("bresp", 32'(bus.s_bresp), 32'(exp_bresp.pop_front()));
            end
            if (bus.s_rvalid && bus.s_rready) begin
                if (exp_rdata.size() == 0) fail_now("r_unexpected");
                else begin
                    check("rdata", bus.s_rdata, exp_rdata.pop_front());
                    check("rresp", 32'(bus.s_rresp), 32'h0);
                end
            end
        end
    end

    // Waits for a grant; returns #1 after the handshake edge.
    task automatic wait_grant(input string name, output logic got_aw, output logic got_ar);
        got_aw = 1'b0;
        got_ar = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.s_awready || bus.s_arready) begin
                got_aw = bus.s_awready && bus.s_wready;
                got_ar = bus.s_arready;
                break;
            end
        end
        if (!got_aw && !got_ar) fail_now({name, "_timeout"});
        else @(posedge clk);
        #1;
    endtask

    // Counts cycles from the handshake edge to the response valid, then lets
    // the response complete (ready assumed high).
    task automatic wait_valid(input string name, input bit is_read, input int exp_lat);
        int n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (is_read ? bus.s_rvalid : bus.s_bvalid) break;
        end
        check(name, 32'(n), 32'(exp_lat));
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        logic g_aw, g_ar;
        exp_bram.push_back('{addr: addr & ~22'h3, we: strb, data: data});
        exp_bresp.push_back(2'b00);
        bus.s_awaddr  = addr;
        bus.s_wdata   = data;
        bus.s_wstrb   = strb;
        bus.s_awvalid = 1'b1;
        bus.s_wvalid  = 1'b1;
        wait_grant("wr_grant", g_aw, g_ar);
        check("wr_grant", 32'(g_aw), 32'h1);
        bus.s_awvalid = 1'b0;
        bus.s_wvalid  = 1'b0;
        wait_valid("b_latency", 1'b0, 2);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [31:0] exp);
        logic g_aw, g_ar;
        exp_bram.push_back('{addr: addr & ~22'h3, we: 4'h0, data: 32'h0});
        exp_rdata.push_back(exp);
        bus.s_araddr  = addr;
        bus.s_arvalid = 1'b1;
        wait_grant("rd_grant", g_aw, g_ar);
        check("rd_grant", 32'(g_ar), 32'h1);
        bus.s_arvalid = 1'b0;
        wait_valid("r_latency", 1'b1, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic g_aw, g_ar;
        int n;
        bus.s_awaddr = '0;  bus.s_awvalid = 1'b1;
        bus.s_wdata  = '0;  bus.s_wstrb   = '0;   bus.s_wvalid = 1'b1;
        bus.s_araddr = '0;  bus.s_arvalid = 1'b1;
        bus.s_bready = 1'b1; bus.s_rready = 1'b1;

        // Reset state, with every request valid held high.
        repeat (3) @(negedge clk);
        check("rst_ready", 32'({bus.s_awready, bus.s_wready, bus.s_arready}), 32'h0);
        check("rst_valid", 32'({bus.s_bvalid, bus.s_rvalid}), 32'h0);
        check("rst_bram_en_we", 32'({bus.bram_en, bus.bram_we}), 32'h0);
        check("rst_bram_addr", 32'(bus.bram_addr), 32'h0);
        check("rst_bram_wrdata", bus.bram_wrdata, 32'h0);
        check("rst_rdata", bus.s_rdata, 32'h0);
        check("rst_resp", 32'({bus.s_bresp, bus.s_rresp}), 32'h0);
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Unaligned read, then aligned write and read-back.
        axi_read(22'h13, 32'h1234_5678);
        axi_write(22'h10, 32'hDEAD_BEEF, 4'hF);
        axi_read(22'h10, 32'hDEAD_BEEF);

        // Partial strobe: bytes 0 and 2 replaced in 0xA5000008.
        axi_write(22'h20, 32'h1122_3344, 4'h5);
        axi_read(22'h20, 32'hA522_0044);

        // Zero strobe still yields an enable and a B response, memory untouched.
        axi_write(22'h24, 32'hFFFF_FFFF, 4'h0);
        axi_read(22'h24, 32'hA500_0009);

        // Write, read and write all valid together: write, then read, then write.
        exp_bram.push_back('{addr: 22'h30, we: 4'hF, data: 32'hCAFE_F00D});
        exp_bresp.push_back(2'b00);
        bus.s_awaddr = 22'h30; bus.s_wdata = 32'hCAFE_F00D; bus.s_wstrb = 4'hF;
        bus.s_araddr = 22'h40;
        bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
        wait_grant("conflict1", g_aw, g_ar);
        check("conflict1_grant", 32'({g_aw, g_ar}), 32'h2);
        exp_bram.push_back('{addr: 22'h40, we: 4'h0, data: 32'h0});
        exp_rdata.push_back(32'hA500_0010);
        exp_bram.push_back('{addr: 22'h34, we: 4'h3, data: 32'h0BAD_F00D});
        exp_bresp.push_back(2'b00);
        bus.s_awaddr = 22'h34; bus.s_wdata = 32'h0BAD_F00D; bus.s_wstrb = 4'h3;
        wait_grant("conflict2", g_aw, g_ar);
        check("conflict2_grant", 32'({g_aw, g_ar}), 32'h1);
        bus.s_arvalid = 1'b0;
        wait_grant("conflict3", g_aw, g_ar);
        check("conflict3_grant", 32'({g_aw, g_ar}), 32'h2);
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        axi_read(22'h34, 32'hA500_F00D);
        axi_read(22'h30, 32'hCAFE_F00D);

        // Read response held off: data stable, nothing granted, BRAM idle.
        exp_bram.push_back('{addr: 22'h50, we: 4'h0, data: 32'h0});
        exp_rdata.push_back(32'hA500_0014);
        bus.s_rready  = 1'b0;
        bus.s_araddr  = 22'h50;
        bus.s_arvalid = 1'b1;
        wait_grant("hold_grant", g_aw, g_ar);
        bus.s_arvalid = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (bus.s_rvalid) break;
        end
        check("hold_r_latency", 32'(n), 32'h3);
        @(posedge clk); #1;
        exp_bram.push_back('{addr: 22'h54, we: 4'hF, data: 32'h0000_0001});
        exp_bresp.push_back(2'b00);
        exp_bram.push_back('{addr: 22'h58, we: 4'h0, data: 32'h0});
        exp_rdata.push_back(32'hA500_0016);
        bus.s_awaddr = 22'h54; bus.s_wdata = 32'h1; bus.s_wstrb = 4'hF;
        bus.s_araddr = 22'h58;
        bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rvalid", 32'(bus.s_rvalid), 32'h1);
            check("hold_rdata", bus.s_rdata, 32'hA500_0014);
            check("hold_ready", 32'({bus.s_awready, bus.s_wready, bus.s_arready}), 32'h0);
            check("hold_bram_en", 32'(bus.bram_en), 32'h0);
        end
        @(posedge clk); #1 bus.s_rready = 1'b1;
        wait_grant("after_hold1", g_aw, g_ar);
        check("after_hold1_grant", 32'({g_aw, g_ar}), 32'h2);
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        wait_grant("after_hold2", g_aw, g_ar);
        check("after_hold2_grant", 32'({g_aw, g_ar}), 32'h1);
        bus.s_arvalid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // AW alone is not accepted; both readies rise together once W arrives.
        exp_bram.push_back('{addr: 22'h60, we: 4'hF, data: 32'h55AA_55AA});
        exp_bresp.push_back(2'b00);
        bus.s_awaddr = 22'h60; bus.s_wdata = 32'h55AA_55AA; bus.s_wstrb = 4'hF;
        bus.s_awvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("aw_only_ready", 32'({bus.s_awready, bus.s_wready}), 32'h0);
        end
        @(posedge clk); #1 bus.s_wvalid = 1'b1;
        @(negedge clk);
        check("aw_w_ready", 32'({bus.s_awready, bus.s_wready}), 32'h3);
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        wait_valid("aw_w_b_latency", 1'b0, 2);

        // Reset during RWAIT drops the read.
        exp_bram.push_back('{addr: 22'h70, we: 4'h0, data: 32'h0});
        bus.s_araddr  = 22'h70;
        bus.s_arvalid = 1'b1;
        wait_grant("rst_rd_grant", g_aw, g_ar);
        bus.s_arvalid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'({bus.s_rvalid, bus.s_bvalid}), 32'h0);
        check("midrst_bram", 32'({bus.bram_en, bus.bram_we}), 32'h0);
        check("midrst_bram_addr", 32'(bus.bram_addr), 32'h0);
        check("midrst_rdata", bus.s_rdata, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'({bus.s_rvalid, bus.s_bvalid, bus.bram_en}), 32'h0);
        end
        @(posedge clk); #1;

        // Normal operation after reset.
        axi_write(22'h80, 32'h1357_9BDF, 4'hF);
        axi_read(22'h82, 32'h1357_9BDF);

        repeat (3) @(posedge clk);
        check("queues_empty", 32'(exp_bram.size() + exp_bresp.size() + exp_rdata.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
